// File: rtl/countdown_timer.sv
// N-digit BCD countdown timer with tick prescaler, expiry beep and registered seven-segment outputs.
// Optional feature: define COUNTDOWN_AUTO_RELOAD_EN to reload and keep counting on expiry.
module countdown_timer #(
  parameter int                  DIGITS      = 2,
  parameter int                  DIV         = 50_000_000,
  parameter logic [4*DIGITS-1:0] START_VALUE = 'h60,
  parameter int                  BEEP_TICKS  = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  input  logic                  start,
  input  logic                  pause,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [7*DIGITS-1:0]   seg,
  output logic                  running,
  output logic                  done,
  output logic                  beep
);

  localparam int W  = 4 * DIGITS;
  localparam int PW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int BW = (BEEP_TICKS > 1) ? $clog2(BEEP_TICKS + 1) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);
  localparam logic [BW-1:0] BEEP_MAX  = BW'(BEEP_TICKS);

  typedef enum logic [1:0] {IDLE, RUN, PAUSED, EXPIRED} state_t;

  state_t              state_q, state_d;
  logic [W-1:0]        count_q, count_d;
  logic [W-1:0]        reload_q, reload_d;
  logic [PW-1:0]       presc_q, presc_d;
  logic                done_q, done_d;
  logic                beep_q, beep_d;
  logic [BW-1:0]       beep_cnt_q, beep_cnt_d;
  logic [7*DIGITS-1:0] seg_q, seg_d;

  logic                tick;
  logic [PW-1:0]       presc_nxt;
  logic [W-1:0]        count_dec;
  logic [BW-1:0]       beep_cnt_inc;

  function automatic logic [W-1:0] clamp_bcd(input logic [W-1:0] v);
    logic [W-1:0] r;
    r = v;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) r[4*i +: 4] = 4'd9;
    end
    return r;
  endfunction

  // Ripple-borrow BCD decrement; callers guarantee v is non-zero.
  function automatic logic [W-1:0] dec_bcd(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         borrow;
    r      = v;
    borrow = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (borrow) begin
        if (v[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [6:0] seg_digit(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  function automatic logic [7*DIGITS-1:0] seg_encode(input logic [W-1:0] v);
    logic [7*DIGITS-1:0] r;
    r = '0;
    for (int i = 0; i < DIGITS; i++) r[7*i +: 7] = seg_digit(v[4*i +: 4]);
    return r;
  endfunction

  assign tick         = (presc_q == PRESC_MAX);
  assign presc_nxt    = tick ? '0 : presc_q + PW'(1);
  assign count_dec    = dec_bcd(count_q);
  assign beep_cnt_inc = beep_cnt_q + BW'(1);

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    reload_d   = reload_q;
    presc_d    = presc_q;
    done_d     = done_q;
    beep_d     = beep_q;
    beep_cnt_d = beep_cnt_q;
    seg_d      = seg_encode(count_q);

    if (load) begin
      count_d  = clamp_bcd(load_val);
      reload_d = clamp_bcd(load_val);
      state_d  = IDLE;
      presc_d  = '0;
      done_d   = 1'b0;
      beep_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            done_d  = 1'b0;
            presc_d = '0;
            if (count_q != '0) begin
              state_d = RUN;
            end else begin
              count_d = reload_q;
              if (reload_q != '0) state_d = RUN;
            end
          end
        end
        RUN: begin
          done_d = 1'b0;
          if (pause) begin
            state_d = PAUSED;
          end else begin
            presc_d = presc_nxt;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            if (beep_q && tick) begin
              beep_cnt_d = beep_cnt_inc;
              if (beep_cnt_inc == BEEP_MAX) beep_d = 1'b0;
            end
`endif
            // Expiry overrides any beep countdown already in progress.
            if (tick && count_q != '0) begin
              count_d = count_dec;
              if (count_dec == '0) begin
                done_d     = 1'b1;
                beep_d     = 1'b1;
                beep_cnt_d = '0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                if (reload_q != '0) count_d = reload_q;
                else                state_d = EXPIRED;
`else
                state_d = EXPIRED;
`endif
              end
            end
          end
        end
        PAUSED: begin
          if (start) state_d = RUN;
        end
        EXPIRED: begin
          if (start) begin
            count_d    = reload_q;
            beep_d     = 1'b0;
            done_d     = 1'b0;
            presc_d    = '0;
            beep_cnt_d = '0;
            state_d    = RUN;
          end else begin
            presc_d = presc_nxt;
            if (tick) begin
              beep_cnt_d = beep_cnt_inc;
              if (beep_cnt_inc == BEEP_MAX) begin
                beep_d  = 1'b0;
                state_d = IDLE;
              end
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= IDLE;
      count_q    <= START_VALUE;
      reload_q   <= START_VALUE;
      presc_q    <= '0;
      done_q     <= 1'b0;
      beep_q     <= 1'b0;
      beep_cnt_q <= '0;
      seg_q      <= seg_encode(START_VALUE);
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      reload_q   <= reload_d;
      presc_q    <= presc_d;
      done_q     <= done_d;
      beep_q     <= beep_d;
      beep_cnt_q <= beep_cnt_d;
      seg_q      <= seg_d;
    end
  end

  assign bcd     = count_q;
  assign seg     = seg_q;
  assign running = (state_q == RUN);
  assign done    = done_q;
  assign beep    = beep_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Testbench for countdown_timer: directed scenarios with literal checks plus randomized
// stimulus compared every cycle against a decimal behavioural model.
module tb_countdown_timer;

   localparam int DIGITS     = 2;
   localparam int DIV        = 4;
   localparam int BEEP_TICKS = 2;
   localparam int START_DEC  = 10;
   localparam logic [7:0] START_BCD = 8'h10;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
   localparam bit AUTO = 1'b1;
`else
   localparam bit AUTO = 1'b0;
`endif

   localparam int M_IDLE    = 0;
   localparam int M_RUN     = 1;
   localparam int M_PAUSED  = 2;
   localparam int M_EXPIRED = 3;

   bit          clock = 1'b0;
   logic        reset;
   logic        load;
   logic [7:0]  loadVal;
   logic        start;
   logic        pause;
   logic [7:0]  bcd;
   logic [13:0] seg;
   logic        running;
   logic        done;
   logic        beep;

   int nChecks = 0;
   int nFails  = 0;

   int mMode, mCount, mReload, mPhase, mBeepLeft, prevCount;
   bit mDone;
   logic [13:0] expSeg;

   logic [6:0] segLut [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

   countdown_timer #(
      .DIGITS      (DIGITS),
      .DIV         (DIV),
      .START_VALUE (START_BCD),
      .BEEP_TICKS  (BEEP_TICKS)
   ) dut (
      .clock    (clock),
      .reset    (reset),
      .load     (load),
      .load_val (loadVal),
      .start    (start),
      .pause    (pause),
      .bcd      (bcd),
      .seg      (seg),
      .running  (running),
      .done     (done),
      .beep     (beep)
   );

   // Free-running board clock
   always #5 clock = ~clock;

   function automatic logic [7:0] toBcd(input int c);
      logic [3:0] t, o;
      t = 4'(c / 10);
      o = 4'(c % 10);
      return {t, o};
   endfunction

   function automatic logic [13:0] segOf(input int c);
      return {segLut[c / 10], segLut[c % 10]};
   endfunction

   function automatic int clampDec(input logic [7:0] v);
      int t, o;
      t = (v[7:4] > 4'd9) ? 9 : int'(v[7:4]);
      o = (v[3:0] > 4'd9) ? 9 : int'(v[3:0]);
      return t * 10 + o;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      nChecks++;
      if (actual !== expected) begin
         nFails++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Decimal model of the timer, advanced once per rising edge using the inputs that edge sampled
   task automatic modelStep();
      if (!reset) begin
         mMode = M_IDLE; mCount = START_DEC; mReload = START_DEC;
         mPhase = 0; mDone = 1'b0; mBeepLeft = 0;
      end else if (load) begin
         mCount = clampDec(loadVal); mReload = mCount;
         mMode = M_IDLE; mPhase = 0; mDone = 1'b0; mBeepLeft = 0;
      end else begin
         case (mMode)
            M_IDLE: if (start) begin
               mDone = 1'b0;
               mPhase = 0;
               if (mCount == 0) mCount = mReload;
               if (mCount != 0) mMode = M_RUN;
            end
            M_RUN: begin
               mDone = 1'b0;
               if (pause) begin
                  mMode = M_PAUSED;
               end else begin
                  if (mBeepLeft > 0) mBeepLeft--;
                  mPhase++;
                  if (mPhase == DIV) begin
                     mPhase = 0;
                     mCount--;
                     if (mCount == 0) begin
                        mDone = 1'b1;
                        mBeepLeft = BEEP_TICKS * DIV;
                        if (AUTO && mReload != 0) mCount = mReload;
                        else mMode = M_EXPIRED;
                     end
                  end
               end
            end
            M_PAUSED: if (start) mMode = M_RUN;
            default: begin
               if (start) begin
                  mCount = mReload; mDone = 1'b0; mBeepLeft = 0;
                  mPhase = 0; mMode = M_RUN;
               end else begin
                  mPhase = (mPhase + 1) % DIV;
                  mBeepLeft--;
                  if (mBeepLeft == 0) mMode = M_IDLE;
               end
            end
         endcase
      end
   endtask

   // Compare process: every falling edge, advance the model and check all outputs
   initial begin
      @(posedge clock);
      forever begin
         @(negedge clock);
         prevCount = mCount;
         expSeg = reset ? segOf(prevCount) : segOf(START_DEC);
         modelStep();
         checkOutput("model bcd", {24'h0, bcd}, {24'h0, toBcd(mCount)});
         checkOutput("model seg", {18'h0, seg}, {18'h0, expSeg});
         checkOutput("model running", {31'h0, running}, {31'h0, mMode == M_RUN});
         checkOutput("model done", {31'h0, done}, {31'h0, mDone});
         checkOutput("model beep", {31'h0, beep}, {31'h0, mBeepLeft > 0});
      end
   end

   task automatic waitCycles(input int n);
      repeat (n) begin
         @(negedge clock);
         #1;
      end
   endtask

   task automatic applyStimulus(input logic ld, input logic [7:0] lv, input logic st, input logic ps);
      load = ld; loadVal = lv; start = st; pause = ps;
      @(negedge clock);
      #1;
      load = 1'b0; start = 1'b0; pause = 1'b0;
   endtask

   // Directed scenarios followed by randomized traffic
   initial begin
      int sel;
      reset = 1'b0; load = 1'b0; loadVal = 8'h00; start = 1'b0; pause = 1'b0;
      waitCycles(3);
      checkOutput("reset bcd", {24'h0, bcd}, 32'h10);
      checkOutput("reset seg", {18'h0, seg}, {18'h0, 7'h79, 7'h40});
      checkOutput("reset running", {31'h0, running}, 32'h0);
      checkOutput("reset done", {31'h0, done}, 32'h0);
      checkOutput("reset beep", {31'h0, beep}, 32'h0);
      reset = 1'b1;
      waitCycles(1);

`ifndef COUNTDOWN_AUTO_RELOAD_EN
      $display("[TB] scenario 1: full countdown from reset value");
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      waitCycles(3);
      checkOutput("s1 bcd before first tick", {24'h0, bcd}, 32'h10);
      waitCycles(1);
      checkOutput("s1 bcd first tick", {24'h0, bcd}, 32'h09);
      waitCycles(36);
      checkOutput("s1 bcd expiry", {24'h0, bcd}, 32'h00);
      checkOutput("s1 done expiry", {31'h0, done}, 32'h1);
      checkOutput("s1 beep expiry", {31'h0, beep}, 32'h1);
      waitCycles(7);
      checkOutput("s1 beep last cycle", {31'h0, beep}, 32'h1);
      waitCycles(1);
      checkOutput("s1 beep off", {31'h0, beep}, 32'h0);
      checkOutput("s1 running off", {31'h0, running}, 32'h0);
      checkOutput("s1 done held", {31'h0, done}, 32'h1);

      $display("[TB] scenario 2: clamp, pause and resume");
      applyStimulus(1'b1, 8'h3A, 1'b0, 1'b0);
      checkOutput("s2 clamped load", {24'h0, bcd}, 32'h39);
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      waitCycles(6);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
      checkOutput("s2 paused bcd", {24'h0, bcd}, 32'h38);
      waitCycles(20);
      checkOutput("s2 frozen bcd", {24'h0, bcd}, 32'h38);
      checkOutput("s2 paused running", {31'h0, running}, 32'h0);
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      waitCycles(1);
      checkOutput("s2 resume hold", {24'h0, bcd}, 32'h38);
      waitCycles(1);
      checkOutput("s2 resume tick", {24'h0, bcd}, 32'h37);

      $display("[TB] scenario 3: BCD borrow");
      applyStimulus(1'b1, 8'h20, 1'b0, 1'b0);
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      waitCycles(4);
      checkOutput("s3 borrow 20->19", {24'h0, bcd}, 32'h19);
      waitCycles(36);
      checkOutput("s3 count 10", {24'h0, bcd}, 32'h10);
      waitCycles(4);
      checkOutput("s3 borrow 10->09", {24'h0, bcd}, 32'h09);

      $display("[TB] scenario 4: load priority and reset mid-beep");
      applyStimulus(1'b1, 8'h05, 1'b1, 1'b1);
      checkOutput("s4 load priority bcd", {24'h0, bcd}, 32'h05);
      checkOutput("s4 load priority running", {31'h0, running}, 32'h0);
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      waitCycles(20);
      checkOutput("s4 expiry beep", {31'h0, beep}, 32'h1);
      waitCycles(3);
      reset = 1'b0;
      waitCycles(1);
      checkOutput("s4 reset beep", {31'h0, beep}, 32'h0);
      checkOutput("s4 reset bcd", {24'h0, bcd}, 32'h10);
      checkOutput("s4 reset done", {31'h0, done}, 32'h0);
      reset = 1'b1;

      $display("[TB] scenario 5: zero load and single-count expiry");
      applyStimulus(1'b1, 8'h00, 1'b0, 1'b0);
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      checkOutput("s5 zero start running", {31'h0, running}, 32'h0);
      checkOutput("s5 zero start bcd", {24'h0, bcd}, 32'h00);
      applyStimulus(1'b1, 8'h01, 1'b0, 1'b0);
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      waitCycles(4);
      checkOutput("s5 expiry bcd", {24'h0, bcd}, 32'h00);
      checkOutput("s5 expiry done", {31'h0, done}, 32'h1);
      waitCycles(7);
      checkOutput("s5 beep last cycle", {31'h0, beep}, 32'h1);
      waitCycles(1);
      checkOutput("s5 beep off", {31'h0, beep}, 32'h0);
      checkOutput("s5 running off", {31'h0, running}, 32'h0);
`else
      $display("[TB] scenario 6: auto reload");
      applyStimulus(1'b1, 8'h02, 1'b0, 1'b0);
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      waitCycles(4);
      checkOutput("s6 bcd 01", {24'h0, bcd}, 32'h01);
      waitCycles(4);
      checkOutput("s6 reload bcd", {24'h0, bcd}, 32'h02);
      checkOutput("s6 reload running", {31'h0, running}, 32'h1);
      checkOutput("s6 done pulse", {31'h0, done}, 32'h1);
      checkOutput("s6 beep on", {31'h0, beep}, 32'h1);
      waitCycles(1);
      checkOutput("s6 done cleared", {31'h0, done}, 32'h0);
      waitCycles(7);
      checkOutput("s6 second reload bcd", {24'h0, bcd}, 32'h02);
      checkOutput("s6 second done pulse", {31'h0, done}, 32'h1);
      checkOutput("s6 beep held", {31'h0, beep}, 32'h1);
`endif

      $display("[TB] randomized traffic");
      for (int i = 0; i < 4000; i++) begin
         reset   = ($urandom_range(0, 499) != 0);
         load    = ($urandom_range(0, 199) == 0);
         loadVal = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 8'h15)) : 8'($urandom());
         sel     = $urandom_range(0, 29);
         start   = (sel < 3);
         pause   = (sel >= 3 && sel < 5);
         @(negedge clock);
         #1;
      end
      reset = 1'b1; load = 1'b0; start = 1'b0; pause = 1'b0;
      waitCycles(2);

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
